// File: rtl/corr_accum8_32.sv
// rtl/corr_accum8_32.sv - per-lag multiply-accumulate engine with accumulator RAM and read port
module corr_accum8_32 #(
    parameter int LAGS  = 32,
    parameter int AW    = 5,
    parameter int DW    = 8,
    parameter int ACC_W = 32,
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DW-1:0]    sample,
    input  logic             sync,
    input  logic [DW-1:0]    tap,
    input  logic             tap_valid,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [ACC_W-1:0] rd_data,
    output logic             rd_valid,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             busy,
    output logic             sat,
    output logic             ovf
);

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_ACC} state_t;

    state_t           state;
    logic [AW-1:0]    clr_addr;
    logic [AW:0]      lag;
    logic [DW-1:0]    ref_sample;

    logic             s1_valid;
    logic [AW-1:0]    s1_addr;
    logic [2*DW-1:0]  s1_prod;
    logic [ACC_W-1:0] s1_rdata;
    logic             s2_valid;
    logic [AW-1:0]    s2_addr;
    logic [ACC_W-1:0] s2_sum;

    logic             rd_p1;
    logic [AW-1:0]    rd_addr_q;

    logic [ACC_W-1:0] mem [LAGS];

    logic             in_range;
    logic             tap_accept;
    logic             rd_accept;
    logic [ACC_W:0]   sum_full;
    logic             sum_clamp;
    logic [ACC_W-1:0] sum_sat;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [ACC_W-1:0] mem_wdata;

    assign in_range   = lag < (AW+1)'(LAGS);
    assign tap_accept = (state == ST_ACC) && tap_valid && !sync && in_range;
    assign rd_accept  = (state == ST_IDLE) && rd_en;
    assign sum_full   = {1'b0, s1_rdata} + (ACC_W+1)'(s1_prod);
    assign sum_clamp  = sum_full[ACC_W];
    assign sum_sat    = sum_clamp ? '1 : sum_full[ACC_W-1:0];
    assign busy       = (state != ST_IDLE);

    // The clear sweep owns the single write port; accumulation never overlaps it.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = s2_addr;
        mem_wdata = s2_sum;
        if (state == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end else if (s2_valid) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // A resync one tap into a frame revisits lag 0 while its update is still in stage 2.
    always_ff @(posedge clk) begin
        s1_addr  <= lag[AW-1:0];
        s1_prod  <= (2*DW)'(ref_sample) * (2*DW)'(tap);
        s1_rdata <= (s2_valid && s2_addr == lag[AW-1:0]) ? s2_sum : mem[lag[AW-1:0]];
        s2_addr  <= s1_addr;
        s2_sum   <= sum_sat;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state      <= ST_CLEAR;
            clr_addr   <= '0;
            lag        <= '0;
            ref_sample <= '0;
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            frame_cnt  <= '0;
            sat        <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            s1_valid <= tap_accept;
            s2_valid <= s1_valid;
            if (s1_valid && sum_clamp) begin
                sat <= 1'b1;
            end
            case (state)
                ST_CLEAR: begin
                    clr_addr <= clr_addr + AW'(1);
                    if (clr_addr == AW'(LAGS - 1)) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (sync) begin
                        ref_sample <= sample;
                        lag        <= '0;
                        if (frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
                        state      <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (sync) begin
                        ref_sample <= sample;
                        lag        <= '0;
                        if (frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
                    end else begin
                        if (tap_valid) begin
                            if (in_range) lag <= lag + (AW+1)'(1);
                            else          ovf <= 1'b1;
                        end
                        if (!in_range && !s1_valid) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_p1     <= 1'b0;
            rd_addr_q <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_p1     <= rd_accept && !clr;
            rd_addr_q <= rd_addr;
            rd_valid  <= rd_p1 && !clr;
            if (rd_p1 && !clr) begin
                rd_data <= mem[rd_addr_q];
            end
        end
    end

endmodule

// File: tb/tb_corr_accum8_32.sv
// tb/tb_corr_accum8_32.sv - directed-vector bench for corr_accum8_32 (32-bit and 16-bit accumulator builds)
module tb_corr_accum8_32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [7:0]  sample = '0;
    logic        sync = 1'b0;
    logic [7:0]  tap = '0;
    logic        tap_valid = 1'b0;
    logic        rd_en = 1'b0;
    logic [4:0]  rd_addr = '0;

    logic [31:0] rd_data;
    logic        rd_valid;
    logic [23:0] frame_cnt;
    logic        busy, sat, ovf;

    logic [15:0] rd_data16;
    logic        rd_valid16;
    logic [23:0] frame_cnt16;
    logic        busy16, sat16, ovf16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    corr_accum8_32 dut (
        .clk(clk), .rst(rst), .clr(clr), .sample(sample), .sync(sync), .tap(tap),
        .tap_valid(tap_valid), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .frame_cnt(frame_cnt), .busy(busy), .sat(sat), .ovf(ovf)
    );

    corr_accum8_32 #(.ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .clr(clr), .sample(sample), .sync(sync), .tap(tap),
        .tap_valid(tap_valid), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data16),
        .rd_valid(rd_valid16), .frame_cnt(frame_cnt16), .busy(busy16), .sat(sat16), .ovf(ovf16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("idle_wait", 64'(busy), 64'd0);
    endtask

    task automatic count_busy(input int rd_cycles, output int n, output bit saw_valid);
        n = 0;
        saw_valid = 1'b0;
        while (busy === 1'b1 && n < 100) begin
            rd_en   = (n < rd_cycles);
            rd_addr = 5'(n);
            if (rd_valid) saw_valid = 1'b1;
            n++;
            tick();
        end
        rd_en = 1'b0;
    endtask

    task automatic clr_pulse();
        int  n;
        bit  sv;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        count_busy(0, n, sv);
        check("clr_busy_len", 64'(n), 64'd32);
    endtask

    task automatic do_sync(input logic [7:0] s);
        sample = s;
        sync   = 1'b1;
        tick();
        sync   = 1'b0;
    endtask

    task automatic send_taps(input logic [7:0] t, input int n);
        tap       = t;
        tap_valid = 1'b1;
        repeat (n) tick();
        tap_valid = 1'b0;
    endtask

    task automatic read_lag(input int a, input logic [63:0] exp, input logic [63:0] exp16, input bit chk16);
        rd_en   = 1'b1;
        rd_addr = 5'(a);
        tick();
        rd_en = 1'b0;
        check($sformatf("rd_valid_early[%0d]", a), 64'(rd_valid), 64'd0);
        tick();
        check($sformatf("rd_valid[%0d]", a), 64'(rd_valid), 64'd1);
        check($sformatf("rd_data[%0d]", a), 64'(rd_data), exp);
        if (chk16) check($sformatf("rd_data16[%0d]", a), 64'(rd_data16), exp16);
    endtask

    task automatic read_all(input logic [63:0] exp, input logic [63:0] exp16, input bit chk16);
        for (int a = 0; a < 32; a++) read_lag(a, exp, exp16, chk16);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  sv;

        // Reset and the post-reset clear sweep
        tick();
        tick();
        check("reset_busy", 64'(busy), 64'd1);
        check("reset_rd_valid", 64'(rd_valid), 64'd0);
        check("reset_rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;
        count_busy(0, n, sv);
        check("reset_busy_len", 64'(n), 64'd32);
        check("reset_frame_cnt", 64'(frame_cnt), 64'd0);
        check("reset_sat", 64'(sat), 64'd0);
        check("reset_ovf", 64'(ovf), 64'd0);
        read_all(64'd0, 64'd0, 1'b0);

        // sample 3 x tap 5, one frame then four
        do_sync(8'd3);
        check("busy_after_sync", 64'(busy), 64'd1);
        send_taps(8'd5, 32);
        wait_idle();
        check("frame_cnt_1", 64'(frame_cnt), 64'd1);
        read_all(64'd15, 64'd15, 1'b1);
        repeat (3) begin
            do_sync(8'd3);
            send_taps(8'd5, 32);
            wait_idle();
        end
        check("frame_cnt_4", 64'(frame_cnt), 64'd4);
        read_all(64'd60, 64'd60, 1'b1);

        // sample 255 x ramp 0..31
        clr_pulse();
        check("clr_frame_cnt", 64'(frame_cnt), 64'd0);
        do_sync(8'd255);
        tap_valid = 1'b1;
        for (int k = 0; k < 32; k++) begin
            tap = 8'(k);
            tick();
        end
        tap_valid = 1'b0;
        wait_idle();
        for (int k = 0; k < 32; k++) read_lag(k, 64'(255 * k), 64'd0, 1'b0);
        read_lag(31, 64'd7905, 64'd7905, 1'b1);

        // Saturation in the 16-bit build
        clr_pulse();
        repeat (2) begin
            do_sync(8'd255);
            send_taps(8'd255, 32);
            wait_idle();
        end
        check("sat32", 64'(sat), 64'd0);
        check("sat16", 64'(sat16), 64'd1);
        check("frame_cnt_2", 64'(frame_cnt), 64'd2);
        read_all(64'd130050, 64'd65535, 1'b1);

        // Overflowing taps
        clr_pulse();
        do_sync(8'd2);
        send_taps(8'd1, 34);
        wait_idle();
        check("ovf_set", 64'(ovf), 64'd1);
        read_all(64'd2, 64'd2, 1'b1);

        // Resync after 10 taps
        clr_pulse();
        check("ovf_cleared", 64'(ovf), 64'd0);
        do_sync(8'd3);
        send_taps(8'd1, 10);
        do_sync(8'd2);
        send_taps(8'd4, 32);
        wait_idle();
        check("resync_frame_cnt", 64'(frame_cnt), 64'd2);
        for (int k = 0; k < 32; k++) read_lag(k, (k < 10) ? 64'd11 : 64'd8, 64'd0, 1'b0);

        // Resync after one tap: lag 0 read while its previous update is in flight
        clr_pulse();
        do_sync(8'd5);
        send_taps(8'd7, 1);
        do_sync(8'd1);
        send_taps(8'd1, 32);
        wait_idle();
        read_lag(0, 64'd36, 64'd36, 1'b1);
        read_lag(1, 64'd1, 64'd1, 1'b1);
        read_lag(31, 64'd1, 64'd1, 1'b1);

        // sync and tap_valid together in IDLE: the tap belongs to no frame
        clr_pulse();
        sample    = 8'd4;
        sync      = 1'b1;
        tap       = 8'd9;
        tap_valid = 1'b1;
        tick();
        sync      = 1'b0;
        tap_valid = 1'b0;
        send_taps(8'd1, 32);
        wait_idle();
        read_lag(0, 64'd4, 64'd4, 1'b1);
        read_lag(31, 64'd4, 64'd4, 1'b1);

        // clr mid-frame with sticky flags set
        clr_pulse();
        do_sync(8'd255);
        send_taps(8'd255, 32);
        wait_idle();
        do_sync(8'd255);
        send_taps(8'd255, 34);
        wait_idle();
        check("pre_clr_sat16", 64'(sat16), 64'd1);
        check("pre_clr_ovf", 64'(ovf), 64'd1);
        do_sync(8'd3);
        send_taps(8'd5, 10);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        count_busy(20, n, sv);
        check("midacc_clr_busy_len", 64'(n), 64'd32);
        check("rd_during_busy", 64'(sv), 64'd0);
        check("rd_after_busy_0", 64'(rd_valid), 64'd0);
        tick();
        check("rd_after_busy_1", 64'(rd_valid), 64'd0);
        tick();
        check("rd_after_busy_2", 64'(rd_valid), 64'd0);
        check("midacc_frame_cnt", 64'(frame_cnt), 64'd0);
        check("midacc_sat16", 64'(sat16), 64'd0);
        check("midacc_ovf", 64'(ovf), 64'd0);
        read_all(64'd0, 64'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
